// File: rtl/rtc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_pkg: shared BCD types, time limits and digit helpers for rtc_timekeeper
// Revision: 1.0
// ----------------------------------------------------------------------------
package rtc_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    function automatic bcd_pair_t to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Both digits decimal and the pair within 00..max.
    function automatic logic bcd_valid(input bcd_pair_t p, input int max);
        return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9) && (p <= to_bcd(max));
    endfunction

    function automatic bcd_pair_t hr_to_12h(input bcd_pair_t h);
        case (h)
            8'h00:   return 8'h12;
            8'h13:   return 8'h01;
            8'h14:   return 8'h02;
            8'h15:   return 8'h03;
            8'h16:   return 8'h04;
            8'h17:   return 8'h05;
            8'h18:   return 8'h06;
            8'h19:   return 8'h07;
            8'h20:   return 8'h08;
            8'h21:   return 8'h09;
            8'h22:   return 8'h10;
            8'h23:   return 8'h11;
            default: return h;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_mod_counter: two-digit BCD counter wrapping at MAX, clear has priority
// Revision: 1.0
// ----------------------------------------------------------------------------
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] value_o,
    output logic [7:0] next_o,
    output logic       carry_o
);

    localparam bcd_pair_t MAX_BCD = to_bcd(MAX);

    bcd_pair_t value_q;
    bcd_pair_t value_d;

    always_comb begin
        value_d = value_q;
        carry_o = 1'b0;
        if (clr_i) begin
            value_d = 8'h00;
        end else if (inc_i) begin
            if (value_q == MAX_BCD) begin
                value_d = 8'h00;
                carry_o = 1'b1;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign next_o  = value_d;

endmodule
`default_nettype wire

// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_timekeeper: BCD hh:mm:ss clock, prescaler, set buttons, 12/24h, alarm
// Revision: 1.0
// ----------------------------------------------------------------------------
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TEST_DIV    = 1000,
    parameter int ALARM_SEC   = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       set_hour_i,
    input  logic       set_min_i,
    input  logic       test_i,
    input  logic       mode12_i,
    input  logic       alarm_en_i,
    input  logic [7:0] alarm_hr_i,
    input  logic [7:0] alarm_min_i,
    input  logic       alarm_ack_i,
    output logic [3:0] hr_left_o,
    output logic [3:0] hr_right_o,
    output logic [3:0] min_left_o,
    output logic [3:0] min_right_o,
    output logic [3:0] sec_left_o,
    output logic [3:0] sec_right_o,
    output logic       pm_o,
    output logic       tick_o,
    output logic       alarm_o
);

    localparam int DIV_MAX = (CLK_FREQ_HZ > TEST_DIV) ? CLK_FREQ_HZ : TEST_DIV;
    localparam int CNT_W   = $clog2(DIV_MAX);
    localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(CLK_FREQ_HZ - 1);
    localparam logic [CNT_W-1:0] LAST_TEST = CNT_W'(TEST_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             set_hour_q, set_min_q, ack_q;
    logic             sec_zero_q, sec_zero_d;
    logic             alarm_q, alarm_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [7:0]       hr_disp_q, hr_disp_d;
    logic             pm_q, pm_d;

    logic       fire_min, fire_hr, fire_ack, match;
    logic       sec_carry, min_carry;
    logic [7:0] sec_val, min_val, hr_val, hr_next;
    logic [7:0] sec_next_unused, min_next_unused;
    logic       hr_carry_unused;

    assign fire_min = set_min_i & ~set_min_q;
    assign fire_hr  = set_hour_i & ~set_hour_q;
    assign fire_ack = alarm_ack_i & ~ack_q;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (tick_q),
        .clr_i  (fire_min),
        .value_o(sec_val),
        .next_o (sec_next_unused),
        .carry_o(sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (fire_min | sec_carry),
        .clr_i  (1'b0),
        .value_o(min_val),
        .next_o (min_next_unused),
        .carry_o(min_carry)
    );

    // A manual minute step never ripples into the hours.
    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (fire_hr | (min_carry & ~fire_min)),
        .clr_i  (1'b0),
        .value_o(hr_val),
        .next_o (hr_next),
        .carry_o(hr_carry_unused)
    );

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (fire_min) begin
            cnt_d = '0;
        end else if (cnt_q >= (test_i ? LAST_TEST : LAST_NORM)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    assign sec_zero_d = fire_min | sec_carry;
    assign match      = sec_zero_q & alarm_en_i
                      & bcd_valid(alarm_hr_i, HR_MAX) & bcd_valid(alarm_min_i, MIN_MAX)
                      & (hr_val == alarm_hr_i) & (min_val == alarm_min_i);

    always_comb begin
        alarm_d = alarm_q;
        tmo_d   = tmo_q;
        if (!alarm_en_i || fire_ack) begin
            alarm_d = 1'b0;
            tmo_d   = 8'd0;
        end else if (match) begin
            alarm_d = 1'b1;
            tmo_d   = 8'(ALARM_SEC);
        end else if (alarm_q && tick_q) begin
            if (tmo_q <= 8'd1) begin
                alarm_d = 1'b0;
                tmo_d   = 8'd0;
            end else begin
                tmo_d = tmo_q - 8'd1;
            end
        end
    end

    // Display hour is registered from the counter's next value so it lines up with the other digits.
    assign hr_disp_d = mode12_i ? hr_to_12h(hr_next) : hr_next;
    assign pm_d      = (hr_next >= 8'h12);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            set_hour_q <= 1'b0;
            set_min_q  <= 1'b0;
            ack_q      <= 1'b0;
            sec_zero_q <= 1'b0;
            alarm_q    <= 1'b0;
            tmo_q      <= 8'd0;
            hr_disp_q  <= 8'h00;
            pm_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            set_hour_q <= set_hour_i;
            set_min_q  <= set_min_i;
            ack_q      <= alarm_ack_i;
            sec_zero_q <= sec_zero_d;
            alarm_q    <= alarm_d;
            tmo_q      <= tmo_d;
            hr_disp_q  <= hr_disp_d;
            pm_q       <= pm_d;
        end
    end

    assign hr_left_o   = hr_disp_q[7:4];
    assign hr_right_o  = hr_disp_q[3:0];
    assign min_left_o  = min_val[7:4];
    assign min_right_o = min_val[3:0];
    assign sec_left_o  = sec_val[7:4];
    assign sec_right_o = sec_val[3:0];
    assign pm_o        = pm_q;
    assign tick_o      = tick_q;
    assign alarm_o     = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_timekeeper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rtc_timekeeper: random and directed stimulus against a seconds-of-day model
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rtc_timekeeper;

    localparam int CF = 10;
    localparam int TD = 4;
    localparam int AS = 3;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       set_hour_i = 1'b0, set_min_i = 1'b0, test_i = 1'b0, mode12_i = 1'b0;
    logic       alarm_en_i = 1'b0, alarm_ack_i = 1'b0;
    logic [7:0] alarm_hr_i = 8'h00, alarm_min_i = 8'h00;
    logic [3:0] hr_left_o, hr_right_o, min_left_o, min_right_o, sec_left_o, sec_right_o;
    logic       pm_o, tick_o, alarm_o;

    always #5 clk = ~clk;

    rtc_timekeeper #(.CLK_FREQ_HZ(CF), .TEST_DIV(TD), .ALARM_SEC(AS)) dut (
        .clk_i(clk), .rst_i(rst_i), .set_hour_i(set_hour_i), .set_min_i(set_min_i),
        .test_i(test_i), .mode12_i(mode12_i), .alarm_en_i(alarm_en_i),
        .alarm_hr_i(alarm_hr_i), .alarm_min_i(alarm_min_i), .alarm_ack_i(alarm_ack_i),
        .hr_left_o(hr_left_o), .hr_right_o(hr_right_o), .min_left_o(min_left_o),
        .min_right_o(min_right_o), .sec_left_o(sec_left_o), .sec_right_o(sec_right_o),
        .pm_o(pm_o), .tick_o(tick_o), .alarm_o(alarm_o)
    );

    typedef logic [26:0] obs_t;
    obs_t q[$];
    int   n_chk = 0, n_pass = 0, n_print = 0;

    // Reference model: time as seconds of the day plus a few flags.
    int m_t, m_cnt, m_tmo, m_hd;
    bit m_tick, m_psm, m_psh, m_pack, m_sz, m_alarm, m_pm;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int bin(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit al_valid(input logic [7:0] v, input int mx);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bin(v) <= mx);
    endfunction

    function automatic obs_t model_obs();
        return {bcd(m_hd), bcd((m_t / 60) % 60), bcd(m_t % 60), m_pm, m_tick, m_alarm};
    endfunction

    task automatic model_reset();
        m_t = 0; m_cnt = 0; m_tmo = 0; m_hd = 0;
        m_tick = 0; m_psm = 0; m_psh = 0; m_pack = 0; m_sz = 0; m_alarm = 0; m_pm = 0;
    endtask

    task automatic model_step();
        int p, h, m, s, h2, m2, s2, t2;
        bit fm, fh, fa, match;
        p  = test_i ? TD : CF;
        fm = set_min_i && !m_psm;
        fh = set_hour_i && !m_psh;
        fa = alarm_ack_i && !m_pack;
        h  = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        match = m_sz && alarm_en_i && al_valid(alarm_hr_i, 23) && al_valid(alarm_min_i, 59)
                && h == bin(alarm_hr_i) && m == bin(alarm_min_i);
        if (!alarm_en_i || fa) begin
            m_alarm = 0; m_tmo = 0;
        end else if (match) begin
            m_alarm = 1; m_tmo = AS;
        end else if (m_alarm && m_tick) begin
            m_tmo--;
            if (m_tmo == 0) m_alarm = 0;
        end
        h2 = h; m2 = m; s2 = s;
        if (fm) begin
            m2 = (m + 1) % 60; s2 = 0;
        end else if (m_tick) begin
            t2 = (m_t + 1) % 86400;
            h2 = t2 / 3600; m2 = (t2 / 60) % 60; s2 = t2 % 60;
        end
        if (fh) h2 = (h + 1) % 24;
        m_sz = fm || (m_tick && s == 59);
        m_t  = h2 * 3600 + m2 * 60 + s2;
        if (fm) begin
            m_cnt = 0; m_tick = 0;
        end else if (m_cnt >= p - 1) begin
            m_cnt = 0; m_tick = 1;
        end else begin
            m_cnt++; m_tick = 0;
        end
        m_hd = !mode12_i ? h2 : (h2 == 0 ? 12 : (h2 > 12 ? h2 - 12 : h2));
        m_pm = (h2 >= 12);
        m_psm = set_min_i; m_psh = set_hour_i; m_pack = alarm_ack_i;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            if (!rst_i) model_reset();
            else model_step();
            q.push_back(model_obs());
            @(negedge clk);
        end
    endtask

    task automatic press_min();
        set_min_i = 1'b1; cyc(2); set_min_i = 1'b0; cyc(2);
    endtask

    task automatic press_hr();
        set_hour_i = 1'b1; cyc(2); set_hour_i = 1'b0; cyc(2);
    endtask

    // Reset lands mid-cycle; the first expectation is checked before any clock edge.
    task automatic async_reset();
        model_reset();
        q.push_back(model_obs());
        rst_i = 1'b0;
        cyc(3);
        rst_i = 1'b1;
    endtask

    task automatic wait_alarm();
        for (int i = 0; i < 1000 && !m_alarm; i++) cyc(1);
        if (!m_alarm) begin
            n_chk++;
            $display("FAIL alarm_wait: model alarm not reached within 1000 cycles, required within bound");
        end
    endtask

    initial begin : monitor
        obs_t exp_v, act_v;
        forever begin
            @(posedge clk or negedge rst_i);
            #1;
            if (q.size() > 0) begin
                exp_v = q.pop_front();
                act_v = {hr_left_o, hr_right_o, min_left_o, min_right_o, sec_left_o, sec_right_o,
                         pm_o, tick_o, alarm_o};
                n_chk++;
                if (act_v === exp_v) begin
                    n_pass++;
                end else if (n_print < 20) begin
                    n_print++;
                    $display("FAIL obs @%0t: got %h:%h:%h pm=%b tick=%b alarm=%b, want %h:%h:%h pm=%b tick=%b alarm=%b",
                             $time, act_v[26:19], act_v[18:11], act_v[10:3], act_v[2], act_v[1], act_v[0],
                             exp_v[26:19], exp_v[18:11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin : stimulus
        @(negedge clk);
        cyc(3);
        rst_i = 1'b1;
        cyc(605);

        repeat (23) press_hr();
        repeat (58) press_min();
        test_i = 1'b1;
        cyc(300);
        mode12_i = 1'b1;
        cyc(10);
        repeat (13) press_hr();
        cyc(10);
        repeat (59) press_min();
        cyc(37 * TD);
        press_min();
        set_min_i = 1'b1; cyc(50); set_min_i = 1'b0; cyc(5);
        set_hour_i = 1'b1; cyc(50); set_hour_i = 1'b0; cyc(5);

        test_i = 1'b0; cyc(7);
        test_i = 1'b1; cyc(3);
        test_i = 1'b0; cyc(3);
        test_i = 1'b1; cyc(20);
        mode12_i = 1'b0;

        alarm_hr_i = 8'h00; alarm_min_i = 8'h02; alarm_en_i = 1'b1;
        async_reset(); wait_alarm(); cyc(30);
        async_reset(); wait_alarm(); cyc(5);
        alarm_ack_i = 1'b1; cyc(2); alarm_ack_i = 1'b0; cyc(10);
        async_reset(); wait_alarm(); cyc(2);
        async_reset(); cyc(5);
        alarm_hr_i = 8'h24;
        async_reset(); cyc(600);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) set_min_i = ~set_min_i;
            if ($urandom_range(0, 31) == 0) set_hour_i = ~set_hour_i;
            if ($urandom_range(0, 9) == 0) alarm_ack_i = ~alarm_ack_i;
            if ($urandom_range(0, 59) == 0) test_i = ~test_i;
            if ($urandom_range(0, 39) == 0) mode12_i = ~mode12_i;
            if ($urandom_range(0, 79) == 0) alarm_en_i = ~alarm_en_i;
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    alarm_hr_i  = bcd(m_t / 3600);
                    alarm_min_i = bcd(((m_t / 60) + 1) % 60);
                end else begin
                    alarm_hr_i  = 8'($urandom);
                    alarm_min_i = 8'($urandom);
                end
            end
            if ($urandom_range(0, 1499) == 0) async_reset();
            cyc(1);
        end

        cyc(2);
        @(posedge clk);
        #2;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
